// File: rtl/pipelined_iir.sv
// pipelined_iir: 12th-order Q20 IIR bandstop, feed-forward sum registered ahead of the 1-cycle feedback loop.
// Define IIR_OUT_SAT_EN to saturate the output and its feedback instead of wrapping.
module pipelined_iir #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 20,
  parameter int ACC_W  = 72
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y
);

  localparam int ORD = 12;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t B [0:ORD] = '{
    631178, -5401947, 23050644, -63646908,
    125716872, -186294288, 211911376, -186294288,
    125716872, -63646908, 23050644, -5401947,
    631178
  };

  localparam acc_t A [1:ORD] = '{
    -8218189, 32107544, -81217352, 147076592,
    -199990256, 208937824, -168854944, 104844152,
    -48879952, 16314139, -3525584, 379931
  };

  logic signed [DATA_W-1:0] xd [1:ORD];
  logic signed [DATA_W-1:0] yh [1:ORD];

  acc_t ff_next;
  acc_t ff_reg;
  acc_t acc;

  logic signed [DATA_W-1:0] y_next;

  always_comb begin
    ff_next = B[0] * acc_t'(x);
    for (int k = 1; k <= ORD; k++) begin
      ff_next = ff_next + B[k] * acc_t'(xd[k]);
    end
  end

  // Feedback closes in one cycle: only ff_reg is pipelined.
  always_comb begin
    acc = ff_reg;
    for (int k = 1; k <= ORD; k++) begin
      acc = acc - A[k] * acc_t'(yh[k]);
    end
  end

`ifdef IIR_OUT_SAT_EN
  localparam acc_t Y_MAX = acc_t'({1'b0, {(DATA_W-1){1'b1}}});
  localparam acc_t Y_MIN = ~Y_MAX;

  acc_t sh;

  assign sh = acc >>> FRAC_W;

  always_comb begin
    y_next = sh[DATA_W-1:0];
    if (sh > Y_MAX) begin
      y_next = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (sh < Y_MIN) begin
      y_next = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end
`else
  assign y_next = DATA_W'(acc >>> FRAC_W);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff_reg <= '0;
      for (int k = 1; k <= ORD; k++) begin
        xd[k] <= '0;
        yh[k] <= '0;
      end
    end else begin
      ff_reg <= ff_next;
      xd[1]  <= x;
      yh[1]  <= y_next;
      for (int k = 2; k <= ORD; k++) begin
        xd[k] <= xd[k-1];
        yh[k] <= yh[k-1];
      end
    end
  end

  assign y = yh[1];

endmodule

// File: tb/tb_pipelined_iir.sv
// tb_pipelined_iir: random and directed streams against a recurrence model,
// expected samples queued at issue and popped by an independent monitor.
module tb_pipelined_iir;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 20;
  localparam int ACC_W  = 72;

  typedef logic signed [95:0] wide_t;

  localparam longint BC [13] = '{
    631178, -5401947, 23050644, -63646908,
    125716872, -186294288, 211911376, -186294288,
    125716872, -63646908, 23050644, -5401947,
    631178
  };

  localparam longint AC [13] = '{
    1048576, -8218189, 32107544, -81217352,
    147076592, -199990256, 208937824, -168854944,
    104844152, -48879952, 16314139, -3525584,
    379931
  };

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [DATA_W-1:0] x = '0;
  logic signed [DATA_W-1:0] y;

  pipelined_iir #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .x    (x),
    .y    (y)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic in_valid = 1'b0;
  logic signed [31:0] exp_q [$];
  logic signed [31:0] mx [13];
  logic signed [31:0] my [13];

  function automatic void model_reset();
    for (int k = 0; k < 13; k++) begin
      mx[k] = '0;
      my[k] = '0;
    end
  endfunction

  // y[n] = floor((sum b_k x[n-k] - sum a_k y[n-k]) / 2^20), narrowed to 32 bits
  function automatic logic signed [31:0] model_step(input logic signed [31:0] xn);
    wide_t ff;
    wide_t acc;
    wide_t r;
    wide_t hi;
    wide_t lo;
    logic signed [31:0] yn;
    for (int k = 12; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = xn;
    ff = '0;
    for (int k = 0; k <= 12; k++) ff = ff + wide_t'(BC[k]) * wide_t'(mx[k]);
    acc = ff;
    for (int k = 1; k <= 12; k++) acc = acc - wide_t'(AC[k]) * wide_t'(my[k]);
    r  = acc >>> FRAC_W;
    hi = (wide_t'(1) <<< 31) - wide_t'(1);
    lo = -(wide_t'(1) <<< 31);
    yn = r[31:0];
`ifdef IIR_OUT_SAT_EN
    if (r > hi) yn = 32'sh7fffffff;
    else if (r < lo) yn = 32'sh80000000;
`else
    if (r > hi || r < lo) yn = r[31:0];
`endif
    for (int k = 12; k > 1; k--) my[k] = my[k-1];
    my[1] = yn;
    return yn;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] got,
                     input logic signed [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  task automatic issue(input logic signed [31:0] v);
    x = v;
    in_valid = 1'b1;
    exp_q.push_back(model_step(v));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    x = 271391;
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold", y, 0);
    end
    reset = 1'b1;
    x = '0;
    model_reset();
  endtask

  // Monitor: a sample accepted at one edge shows on y after the next edge.
  logic v_d = 1'b0;
  always @(posedge clk) begin : mon
    logic s;
    logic signed [31:0] e;
    s = in_valid & reset;
    #1;
    if (v_d && reset) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: got y=%0d expected a queued sample", y);
      end else begin
        e = exp_q.pop_front();
        chk("stream_y", y, e);
      end
    end
    v_d = s;
  end

  int sine [24];
  int q7 [7];
  int peak;

  initial begin
    q7 = '{0, 271391, 524288, 741455, 908093, 1012846, 1048576};
    for (int k = 0; k < 12; k++) begin
      sine[k]    = (k <= 6) ? q7[k] : q7[12-k];
      sine[k+12] = -sine[k];
    end
    model_reset();

    #1 reset = 1'b0;
    x = 271391;
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", y, 0);
    end
    reset = 1'b1;
    x = '0;

    @(negedge clk);
    issue(1048576);
    @(negedge clk);
    issue(0);
    @(negedge clk);
    chk("impulse_n0", y, 631178);
    issue(0);
    @(negedge clk);
    chk("impulse_n1", y, -455105);
    issue(0);
    repeat (60) begin
      @(negedge clk);
      issue(0);
    end

    do_reset();
    repeat (200) begin
      @(negedge clk);
      issue(0);
    end

    do_reset();
    peak = 0;
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      if (i >= 130 && y > peak) peak = y;
      issue(sine[i % 24]);
    end
    n_cmp++;
    if (peak < 943718 || peak > 1153434) begin
      n_bad++;
      $display("FAIL sine_peak: got %0d expected 943718..1153434", peak);
    end

    do_reset();
    repeat (500) begin
      @(negedge clk);
      issue(1048576);
    end

    do_reset();
    repeat (300) begin
      @(negedge clk);
      issue(int'($urandom_range(2097152)) - 1048576);
    end

    @(posedge clk);
    #3;
    reset = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("async_reset", y, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    x = '0;
    model_reset();

    repeat (100) begin
      @(negedge clk);
      issue(32'sh7fffffff);
    end

    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
